// File: rtl/bottling_sequencer_pkg.sv
// rtl/bottling_sequencer_pkg.sv - shared state codes and default timing/tray constants
package bottling_sequencer_pkg;

  // State codes are also decoded by the display/debug path, so they are fixed values
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MOVE    = 3'd1,
    ST_FILL    = 3'd2,
    ST_SEAL    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  localparam logic [15:0] FILL_TIMEOUT_DEF = 16'd6000;
  localparam logic [7:0]  SEAL_TICKS_DEF   = 8'd30;
  localparam logic [4:0]  TRAY_MAX_DEF     = 5'd20;
  localparam logic [4:0]  TRAY_LOW_DEF     = 5'd5;
  localparam logic [4:0]  REFILL_QTY_DEF   = 5'd15;

endpackage

// File: rtl/bottling_sequencer_if.sv
// rtl/bottling_sequencer_if.sv - station sensor/actuator and cork dispenser signal bundle
interface bottling_sequencer_if;

  logic       enable;
  logic       pg;
  logic       ch;
  logic       refill_ack;
  logic       m;
  logic       ev;
  logic       ve;
  logic       gp;
  logic       refill_req;
  logic       alarm;
  logic [4:0] tray_count;
  logic [2:0] state;

  // Plant side: drives sensors and dispenser acknowledge, observes actuators
  modport master (
    output enable, pg, ch, refill_ack,
    input  m, ev, ve, gp, refill_req, alarm, tray_count, state
  );

  // Sequencer side
  modport slave (
    input  enable, pg, ch, refill_ack,
    output m, ev, ve, gp, refill_req, alarm, tray_count, state
  );

endinterface

// File: rtl/bottling_sequencer_cork_tray_ctrl.sv
// rtl/bottling_sequencer_cork_tray_ctrl.sv - cork tray counter with saturating refill and req/ack handshake
module cork_tray_ctrl
  import bottling_sequencer_pkg::*;
#(
  parameter logic [4:0] TRAY_MAX   = TRAY_MAX_DEF,
  parameter logic [4:0] TRAY_LOW   = TRAY_LOW_DEF,
  parameter logic [4:0] REFILL_QTY = REFILL_QTY_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       consume,
  input  logic       refill_ack,
  output logic [4:0] tray_count,
  output logic       refill_req,
  output logic       empty,
  output logic       empty_next
);

  logic [4:0] tray_q, tray_d;
  logic       req_q, req_d;
  logic       accept;
  logic [5:0] sum;

  // Next tray level and request; an ack only counts while a request is outstanding
  always_comb begin
    accept = refill_ack & req_q;
    sum    = {1'b0, tray_q};
    if (accept) begin
      sum = sum + {1'b0, REFILL_QTY};
    end
    // A consume from an empty tray cannot happen upstream, but never underflow
    if (consume && (tray_q != 5'd0)) begin
      sum = sum - 6'd1;
    end
    tray_d = (sum > {1'b0, TRAY_MAX}) ? TRAY_MAX : sum[4:0];
    req_d  = accept ? 1'b0 : (req_q | (tray_q <= TRAY_LOW));
  end

  // Tray and handshake registers; corks are assumed full after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tray_q <= TRAY_MAX;
      req_q  <= 1'b0;
    end else begin
      tray_q <= tray_d;
      req_q  <= req_d;
    end
  end

  assign tray_count = tray_q;
  assign refill_req = req_q;
  assign empty      = (tray_q == 5'd0);
  assign empty_next = (tray_d == 5'd0);

endmodule

// File: rtl/bottling_sequencer.sv
// rtl/bottling_sequencer.sv - timed conveyor/fill/seal sequencer for one bottling station
module bottling_sequencer
  import bottling_sequencer_pkg::*;
#(
  parameter logic [15:0] FILL_TIMEOUT = FILL_TIMEOUT_DEF,
  parameter logic [7:0]  SEAL_TICKS   = SEAL_TICKS_DEF,
  parameter logic [4:0]  TRAY_MAX     = TRAY_MAX_DEF,
  parameter logic [4:0]  TRAY_LOW     = TRAY_LOW_DEF,
  parameter logic [4:0]  REFILL_QTY   = REFILL_QTY_DEF
) (
  input  logic                clk,
  input  logic                reset,
  bottling_sequencer_if.slave bus
);

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        m_q, m_d;
  logic        ev_q, ev_d;
  logic        ve_q, ve_d;
  logic        gp_q, gp_d;
  logic        alarm_q, alarm_d;
  logic        consume;
  logic        tray_empty;
  logic        tray_empty_next;
  logic [4:0]  tray_count;
  logic        refill_req;

  cork_tray_ctrl #(
    .TRAY_MAX   (TRAY_MAX),
    .TRAY_LOW   (TRAY_LOW),
    .REFILL_QTY (REFILL_QTY)
  ) u_tray (
    .clk        (clk),
    .reset      (reset),
    .consume    (consume),
    .refill_ack (bus.refill_ack),
    .tray_count (tray_count),
    .refill_req (refill_req),
    .empty      (tray_empty),
    .empty_next (tray_empty_next)
  );

  // Next state, shared fill/seal timer, and actuator values for the state being entered
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    consume = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable) state_d = ST_MOVE;
      end
      ST_MOVE: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (bus.pg) begin
          state_d = ST_FILL;
          timer_d = 16'd0;
        end
      end
      ST_FILL: begin
        // A full bottle wins over a timeout on the same cycle; enable is ignored
        if (bus.ch) begin
          state_d = ST_SEAL;
          timer_d = 16'd0;
        end else if (timer_q == (FILL_TIMEOUT - 16'd1)) begin
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_SEAL: begin
        // With no cork the press stays idle and the timer freezes until a refill
        if (!tray_empty) begin
          if (timer_q == {8'd0, SEAL_TICKS - 8'd1}) begin
            consume = 1'b1;
            state_d = ST_RELEASE;
            timer_d = 16'd0;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
      end
      ST_RELEASE: begin
        if (!bus.pg) state_d = bus.enable ? ST_MOVE : ST_IDLE;
      end
      ST_FAULT: begin
        if (!bus.enable) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = 16'd0;
      end
    endcase

    m_d     = (state_d == ST_MOVE) || (state_d == ST_RELEASE);
    ev_d    = (state_d == ST_FILL);
    ve_d    = (state_d == ST_SEAL) && !tray_empty_next;
    gp_d    = consume;
    alarm_d = (state_d == ST_FAULT) || tray_empty_next;
  end

  // State, timer and registered actuator outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      timer_q <= 16'd0;
      m_q     <= 1'b0;
      ev_q    <= 1'b0;
      ve_q    <= 1'b0;
      gp_q    <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      m_q     <= m_d;
      ev_q    <= ev_d;
      ve_q    <= ve_d;
      gp_q    <= gp_d;
      alarm_q <= alarm_d;
    end
  end

  assign bus.m          = m_q;
  assign bus.ev         = ev_q;
  assign bus.ve         = ve_q;
  assign bus.gp         = gp_q;
  assign bus.alarm      = alarm_q;
  assign bus.refill_req = refill_req;
  assign bus.tray_count = tray_count;
  assign bus.state      = state_q;

endmodule
